// File: rtl/cp0_timer_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions and read-word packers.
// Used by cp0_timer_ctrl and cp0_count_compare; the timer is gated by the CP0_TIMER_EN macro.
package cp0_timer_ctrl_pkg;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_SR       = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [4:0] CP0_REG_PRID     = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    // Code 31 is unused by the architecture, so it doubles as "no exception".
    localparam logic [4:0] EXC_NONE = 5'd31;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 8;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_EXC_LO = 2;

    localparam logic [31:0] PRID_DEFAULT = 32'h0000_0200;

    function automatic logic [31:0] sr_word(input logic ie, input logic exl, input logic [7:0] im);
        return {16'd0, im, 6'd0, exl, ie};
    endfunction

    function automatic logic [31:0] cause_word(input logic bd, input logic ti,
                                               input logic [7:0] ip, input logic [4:0] code);
        return {bd, ti, 14'd0, ip, 1'b0, code, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_timer_ctrl_count_compare.sv
// Count/Compare timer: prescaler, free-running Count, Compare and the sticky TI flag.
// Instantiated by cp0_timer_ctrl only when CP0_TIMER_EN is defined.
module cp0_count_compare
    import cp0_timer_ctrl_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] presc;
    logic          tick;
    logic          match_pend;

    assign tick = (presc == PW'(COUNT_DIV - 1));

    // An equality reached by an increment raises TI one cycle later; writes never raise it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            count      <= '0;
            compare    <= 32'hFFFF_FFFF;
            ti         <= 1'b0;
            match_pend <= 1'b0;
        end else begin
            if (wr_count) begin
                count <= wr_data;
                presc <= '0;
            end else if (tick) begin
                count <= count + 32'd1;
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            if (wr_compare) begin
                compare    <= wr_data;
                ti         <= 1'b0;
                match_pend <= 1'b0;
            end else begin
                match_pend <= tick && !wr_count && ((count + 32'd1) == compare);
                if (match_pend)
                    ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_timer_ctrl.sv
// Coprocessor-0 beside the M stage: SR/Cause/EPC/PRId/BadVAddr, interrupt/exception entry.
// Define CP0_TIMER_EN to include the Count/Compare timer; otherwise regs 9/11 read 0 and TI is 0.
module cp0_timer_ctrl
    import cp0_timer_ctrl_pkg::*;
#(
    parameter int          NUM_HWIRQ = 6,
    parameter int          COUNT_DIV = 2,
    parameter logic [31:0] PRID_VAL  = PRID_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           addr,
    input  logic                 write_enable,
    input  logic [31:0]          write_data,
    input  logic                 exit_isr,
    input  logic                 in_bds,
    input  logic [NUM_HWIRQ-1:0] hwirq,
    input  logic [4:0]           exc,
    input  logic [31:0]          curr_pc,
    input  logic [31:0]          bad_vaddr,
    output logic [31:0]          read_result,
    output logic [31:0]          epc,
    output logic                 have2handle,
    output logic                 timer_irq
);
    logic        sr_ie, sr_exl, cause_bd;
    logic [7:0]  sr_im;
    logic [1:0]  sw_ip;
    logic [4:0]  exc_code;
    logic [31:0] epc_q, badvaddr_q;
    logic [31:0] count, compare;
    logic        ti;
    logic [5:0]  hw_ip;
    logic [7:0]  ip;
    logic        have_irq, have_exc, mtc0;
    logic        unused_pc_bits;

    if (NUM_HWIRQ < 1 || NUM_HWIRQ > 6 || COUNT_DIV < 1) begin : g_param_check
        $error("cp0_timer_ctrl: NUM_HWIRQ or COUNT_DIV out of range");
    end

    always_comb begin
        hw_ip = '0;
        hw_ip[NUM_HWIRQ-1:0] = hwirq;
    end

    // IP[15] is shared between the last hardware line and the timer.
    assign ip          = {hw_ip[5] | ti, hw_ip[4:0], sw_ip};
    assign have_irq    = (|(ip & sr_im)) & sr_ie & ~sr_exl;
    assign have_exc    = (exc != EXC_NONE) & ~sr_exl;
    assign have2handle = have_irq | have_exc;
    assign mtc0        = write_enable & ~have2handle;
    assign epc         = epc_q;
    assign timer_irq   = ti;
    assign unused_pc_bits = ^curr_pc[1:0];

`ifdef CP0_TIMER_EN
    cp0_count_compare #(.COUNT_DIV(COUNT_DIV)) u_count_compare (
        .clk        (clk),
        .rst        (rst),
        .wr_count   (mtc0 && (addr == CP0_REG_COUNT)),
        .wr_compare (mtc0 && (addr == CP0_REG_COMPARE)),
        .wr_data    (write_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    always_comb begin
        read_result = '0;
        case (addr)
            CP0_REG_BADVADDR: read_result = badvaddr_q;
            CP0_REG_COUNT:    read_result = count;
            CP0_REG_COMPARE:  read_result = compare;
            CP0_REG_SR:       read_result = sr_word(sr_ie, sr_exl, sr_im);
            CP0_REG_CAUSE:    read_result = cause_word(cause_bd, ti, ip, exc_code);
            CP0_REG_EPC:      read_result = epc_q;
            CP0_REG_PRID:     read_result = PRID_VAL;
            default:          read_result = '0;
        endcase
    end

    // Exception entry outranks mtc0, which outranks eret.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_ie      <= 1'b0;
            sr_exl     <= 1'b0;
            sr_im      <= '0;
            cause_bd   <= 1'b0;
            sw_ip      <= '0;
            exc_code   <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else if (have2handle) begin
            sr_exl   <= 1'b1;
            cause_bd <= in_bds;
            epc_q    <= {curr_pc[31:2], 2'b00} - (in_bds ? 32'd4 : 32'd0);
            exc_code <= have_irq ? EXC_INT : exc;
            if (!have_irq && (exc == EXC_ADEL || exc == EXC_ADES))
                badvaddr_q <= bad_vaddr;
        end else if (mtc0) begin
            case (addr)
                CP0_REG_SR: begin
                    sr_ie  <= write_data[SR_IE];
                    sr_exl <= write_data[SR_EXL];
                    sr_im  <= write_data[SR_IM_LO +: 8];
                end
                CP0_REG_CAUSE: sw_ip <= write_data[CAUSE_IP_LO +: 2];
                CP0_REG_EPC:   epc_q <= write_data;
                default: ;
            endcase
        end else if (exit_isr) begin
            sr_exl <= 1'b0;
        end
    end

endmodule

// File: doc/cp0_timer_ctrl.md
Name: cp0_timer_ctrl

Overview:
- Parametrised coprocessor-0 successor for the pipelined MIPS datapath. Sits beside the M stage.
- Holds SR, Cause, EPC, PRId, BadVAddr, Count and Compare.
- Supports 1..6 maskable hardware IRQ lines, two software interrupts and an internal Count/Compare timer interrupt.
- Raises have2handle to redirect the pipeline into the exception handler.

Parameters:
NUM_HWIRQ, 6, external IRQ lines, 1..6; line i maps to Cause/SR bit 10+i.
COUNT_DIV, 2, clk cycles per Count increment, >=1.
PRID_VAL, 32'h0000_0200, value returned for PRId.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
addr  in  5  CP0 register number for mfc0/mtc0
write_enable  in  1  mtc0 strobe
write_data  in  32  mtc0 data
exit_isr  in  1  eret retiring; clears EXL
in_bds  in  1  faulting/interrupted instruction is in a delay slot
hwirq  in  NUM_HWIRQ  level-sensitive external interrupts
exc  in  5  exception code from pipeline; EXC_NONE when none
curr_pc  in  32  PC of faulting/interrupted instruction
bad_vaddr  in  32  faulting address for AdEL/AdES
read_result  out  32  mfc0 data, combinational
epc  out  32  current EPC
have2handle  out  1  take exception/interrupt this cycle, combinational
timer_irq  out  1  Cause.TI, registered

Behaviour:
- Register map:
  - 8 BadVAddr (RO); 9 Count (RW); 11 Compare (RW); 12 SR; 13 Cause; 14 EPC (RW); 15 PRId (RO).
  - Any other address reads 0; writes to it are ignored.
- SR fields: IE=bit0, EXL=bit1, IM=[15:8]; all other bits read 0.
- Cause fields: BD=31, TI=30, IP=[15:8] (IP[9:8] software, IP[15:10] hardware), ExcCode=[6:2]; all other bits 0.
- Reset (async, rst=1): SR=0, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=32'hFFFF_FFFF, prescaler=0. Outputs follow: have2handle=0, timer_irq=0, epc=0.
- Every cycle IP[15:10] samples hwirq. Missing lines read 0. IP[15] = hwirq[5] | TI (TI wins if NUM_HWIRQ<6).
- have_irq = |(IP & IM) & IE & ~EXL.
- have_exc = (exc != EXC_NONE) & ~EXL.
- have2handle = have_irq | have_exc.
- Handling edge, when have2handle=1:
  - EXL<=1; BD<=in_bds.
  - EPC <= {curr_pc[31:2],2'b00} minus 4 if in_bds.
  - ExcCode <= 0 if have_irq (interrupt has priority), else exc.
  - BadVAddr <= bad_vaddr only if the taken cause is AdEL(4) or AdES(5).
  - Any mtc0 in the same cycle is discarded.
- mtc0 (write_enable, have2handle=0):
  - SR: IE, EXL, IM only.
  - Cause: only IP[9:8] writable.
  - EPC: full 32 bits.
  - Count: load value; prescaler cleared.
  - Compare: load value; TI cleared.
- exit_isr with no write and no have2handle: EXL<=0.
- Writes take effect on the next cycle; read_result is combinational, so a same-cycle read returns the old value.
- Timer:
  - Prescaler counts 0..COUNT_DIV-1; Count increments by 1 on wrap, 32-bit modular, 32'hFFFF_FFFF wraps to 0.
  - TI sets (sticky) on the cycle after Count becomes equal to Compare through an increment. A write that makes them equal does not set TI.
  - TI is cleared only by a Compare write or reset.
- Simultaneous events:
  - Count write vs increment: write wins.
  - Compare write vs match: write wins, TI=0.
  - have2handle vs Count/Compare timer update: timer still advances.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Optional Feature:
CP0_TIMER_EN.
- Defined: Count/Compare/TI implemented as above.
- Undefined: addresses 9 and 11 read 0 and ignore writes; TI constant 0; timer_irq tied 0; no prescaler logic instantiated.

Decomposition:
- Shared package/header: register numbers (CP0_REG_*), EXC codes (EXC_NONE, EXC_INT, EXC_ADEL, EXC_ADES, ...), SR/Cause bit positions, default PRId.
- Sub-module cp0_count_compare: prescaler, Count, Compare, TI. Instantiated under CP0_TIMER_EN.

Test Plan:
- Reset, then read 12/13/14 -> 0; read 15 -> 32'h0000_0200; read 11 -> 32'hFFFF_FFFF.
- Write SR=32'h0000_0401, then hwirq[0]=1, curr_pc=32'h0000_3008, in_bds=0 -> have2handle=1 same cycle. Next cycle: EPC=32'h3008, ExcCode=0, EXL=1, have2handle=0.
- exc=4 (AdEL), in_bds=1, curr_pc=32'h3010, bad_vaddr=32'h0000_1001 -> EPC=32'h300C, BD=1, ExcCode=4, BadVAddr=32'h1001. Then exit_isr -> EXL=0.
- COUNT_DIV=2: write Count=5, Compare=8 -> TI rises at cycle 7 after the write (Count=8), timer_irq=1. Write Compare=20 -> TI=0 next cycle.
- Count=32'hFFFF_FFFF -> wraps to 0 after COUNT_DIV cycles. mtc0 Count coincident with an increment -> written value held.
- mtc0 SR coincident with exc=10 -> SR write dropped, exception taken. Assert rst mid-cycle with TI=1 -> timer_irq=0 immediately.
